mem_channel_dispatcher: RTL and testbench



---
 rtl/mem_channel_dispatcher.sv | 152 +++++++++++++++
 tb/tb_mem_channel_dispatcher.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_channel_dispatcher.sv
// ============================================================================
// Module   : mem_channel_dispatcher
// Purpose  : N-channel command split / read-credit throttle / return re-align
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_channel_dispatcher #(
    parameter int NUM_CHANNELS   = 2,
    parameter int ADDR_WIDTH     = 30,
    parameter int DATA_WIDTH     = 512,
    parameter int CMD_FIFO_DEPTH = 16,
    parameter int RET_FIFO_DEPTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cmd_valid,
    input  logic                               cmd_wr,
    input  logic [ADDR_WIDTH-1:0]              cmd_addr,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] cmd_wdata,
    output logic                               cmd_ready,
    input  logic                               halt,
    input  logic [NUM_CHANNELS-1:0]            avl_ready,
    output logic [NUM_CHANNELS-1:0]            avl_rd,
    output logic [NUM_CHANNELS-1:0]            avl_wr,
    output logic [NUM_CHANNELS*ADDR_WIDTH-1:0] avl_addr,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] avl_wdata,
    input  logic [NUM_CHANNELS-1:0]            avl_rdata_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] avl_rdata,
    output logic                               rdata_valid,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] rdata,
    input  logic                               rdata_ready,
    output logic                               idle,
    output logic                               err
);

    localparam int CAW = $clog2(CMD_FIFO_DEPTH);
    localparam int RAW = $clog2(RET_FIFO_DEPTH);
    localparam int OW  = $clog2(RET_FIFO_DEPTH + 1);
    localparam int EW  = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [OW-1:0]  CREDIT_MAX = OW'(RET_FIFO_DEPTH);
    localparam logic [RAW:0]   RET_FULL   = (RAW+1)'(RET_FIFO_DEPTH);

    logic [NUM_CHANNELS-1:0] cmd_full;
    logic [NUM_CHANNELS-1:0] cmd_empty;
    logic [NUM_CHANNELS-1:0] ret_empty;
    logic [NUM_CHANNELS-1:0] ch_idle;
    logic [NUM_CHANNELS-1:0] err_set;
    logic                    accept;
    logic                    pop;
    logic                    err_q;

    assign cmd_ready   = ~|cmd_full;
    assign accept      = cmd_valid & cmd_ready;
    assign rdata_valid = ~|ret_empty;
    assign pop         = rdata_valid & rdata_ready;
    assign idle        = &ch_idle;
    assign err         = err_q;

    generate
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
            logic [EW-1:0]         cmem [CMD_FIFO_DEPTH];
            logic [CAW:0]          cwr_q;
            logic [CAW:0]          crd_q;
            logic [EW-1:0]         head;
            logic                  head_wr;
            logic                  issue;
            logic [OW-1:0]         out_q;
            logic [OW-1:0]         out_d;
            logic [DATA_WIDTH-1:0] rmem [RET_FIFO_DEPTH];
            logic [RAW:0]          rwr_q;
            logic [RAW:0]          rrd_q;
            logic [RAW:0]          rocc;
            logic                  ret_ok;
            logic                  ret_push;

            // Command FIFO: every channel pushes together, pops independently.
            assign cmd_empty[i] = (cwr_q == crd_q);
            assign cmd_full[i]  = (cwr_q[CAW] != crd_q[CAW]) &&
                                  (cwr_q[CAW-1:0] == crd_q[CAW-1:0]);
            assign head         = cmem[crd_q[CAW-1:0]];
            assign head_wr      = head[0];
            assign issue        = ~cmd_empty[i] & avl_ready[i] & ~halt &
                                  (head_wr | (out_q < CREDIT_MAX));

            assign avl_wr[i] = issue & head_wr;
            assign avl_rd[i] = issue & ~head_wr;
            assign avl_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = head[EW-1 -: ADDR_WIDTH];
            assign avl_wdata[i*DATA_WIDTH +: DATA_WIDTH] = head[DATA_WIDTH:1];

            always_ff @(posedge clk) begin
                if (accept) begin
                    cmem[cwr_q[CAW-1:0]] <= {cmd_addr, cmd_wdata[i*DATA_WIDTH +: DATA_WIDTH], cmd_wr};
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cwr_q <= '0;
                    crd_q <= '0;
                end else begin
                    if (accept) cwr_q <= cwr_q + (CAW+1)'(1);
                    if (issue)  crd_q <= crd_q + (CAW+1)'(1);
                end
            end

            always_comb begin
                out_d = out_q;
                if (avl_rd[i] && !pop)      out_d = out_q + OW'(1);
                else if (!avl_rd[i] && pop) out_d = out_q - OW'(1);
            end

            always_ff @(posedge clk) begin
                if (rst) out_q <= '0;
                else     out_q <= out_d;
            end

            // A return is legal only if a read is still owed beyond what is already buffered.
            assign rocc         = rwr_q - rrd_q;
            assign ret_ok       = (rocc != RET_FULL) && (rocc < out_q);
            assign ret_push     = avl_rdata_valid[i] & ret_ok;
            assign err_set[i]   = avl_rdata_valid[i] & ~ret_ok;
            assign ret_empty[i] = (rwr_q == rrd_q);
            assign rdata[i*DATA_WIDTH +: DATA_WIDTH] = rmem[rrd_q[RAW-1:0]];
            assign ch_idle[i]   = cmd_empty[i] & (out_q == '0);

            always_ff @(posedge clk) begin
                if (ret_push) begin
                    rmem[rwr_q[RAW-1:0]] <= avl_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rwr_q <= '0;
                    rrd_q <= '0;
                end else begin
                    if (ret_push) rwr_q <= rwr_q + (RAW+1)'(1);
                    if (pop)      rrd_q <= rrd_q + (RAW+1)'(1);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst)           err_q <= 1'b0;
        else if (|err_set) err_q <= 1'b1;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_channel_dispatcher.sv
// ============================================================================
// Module   : tb_mem_channel_dispatcher
// Purpose  : directed self-checking bench for mem_channel_dispatcher
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_channel_dispatcher;

    localparam int NC = 2;
    localparam int AW = 30;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_wr;
    logic [AW-1:0]   cmd_addr;
    logic [NC*DW-1:0] cmd_wdata;
    logic            cmd_ready;
    logic            halt;
    logic [NC-1:0]   avl_ready;
    logic [NC-1:0]   avl_rd;
    logic [NC-1:0]   avl_wr;
    logic [NC*AW-1:0] avl_addr;
    logic [NC*DW-1:0] avl_wdata;
    logic [NC-1:0]   avl_rdata_valid;
    logic [NC*DW-1:0] avl_rdata;
    logic            rdata_valid;
    logic [NC*DW-1:0] rdata;
    logic            rdata_ready;
    logic            idle;
    logic            err;

    int errors = 0;
    int checks = 0;

    mem_channel_dispatcher #(
        .NUM_CHANNELS(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .CMD_FIFO_DEPTH(16), .RET_FIFO_DEPTH(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready), .halt(halt),
        .avl_ready(avl_ready), .avl_rd(avl_rd), .avl_wr(avl_wr),
        .avl_addr(avl_addr), .avl_wdata(avl_wdata),
        .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
        .rdata_valid(rdata_valid), .rdata(rdata), .rdata_ready(rdata_ready),
        .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] both_addr(input logic [AW-1:0] a);
        return {4'h0, a, a};
    endfunction

    initial begin
        int acc;
        int rd0;
        int rd1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        logic [NC*DW-1:0] w;

        rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        halt = 1'b0; avl_ready = 2'b11; avl_rdata_valid = '0; avl_rdata = '0;
        rdata_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_avl_rd", 64'(avl_rd), 64'd0);
        check("rst_avl_wr", 64'(avl_wr), 64'd0);
        check("rst_rdata_valid", 64'(rdata_valid), 64'd0);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_err", 64'(err), 64'd0);

        // four reads, issued one cycle after acceptance
        for (int k = 0; k < 4; k++) begin
            cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = AW'(32'h10 + k);
            #1;
            check("rd_issue", 64'(avl_rd), (k == 0) ? 64'd0 : 64'd3);
            if (k > 0) check("rd_addr", 64'(avl_addr), both_addr(AW'(32'h10 + k - 1)));
            tick();
        end
        cmd_valid = 1'b0;
        #1;
        check("rd_issue_last", 64'(avl_rd), 64'd3);
        check("rd_addr_last", 64'(avl_addr), both_addr(AW'(32'h13)));
        tick();
        check("rd_done", 64'(avl_rd), 64'd0);
        check("busy_idle", 64'(idle), 64'd0);

        // skewed returns: channel 1 three cycles behind channel 0
        for (int j = 0; j < 9; j++) begin
            d0 = 16'hA000 + 16'(j);
            d1 = 16'hB000 + 16'(j - 3);
            avl_rdata_valid = {(j >= 3 && j < 7), (j < 4)};
            avl_rdata = {d1, d0};
            #1;
            check("align_valid", 64'(rdata_valid), (j >= 4 && j <= 7) ? 64'd1 : 64'd0);
            if (j >= 4 && j <= 7) begin
                w = {16'hB000 + 16'(j - 4), 16'hA000 + 16'(j - 4)};
                check("align_word", 64'(rdata), 64'(w));
            end
            tick();
        end
        avl_rdata_valid = '0;
        #1;
        check("align_idle", 64'(idle), 64'd1);
        check("align_err", 64'(err), 64'd0);

        // credit limit: 20 reads, no returns
        acc = 0; rd0 = 0; rd1 = 0;
        for (int c = 0; c < 30; c++) begin
            cmd_valid = (acc < 20); cmd_wr = 1'b0; cmd_addr = AW'(32'h100 + acc);
            #1;
            if (cmd_valid && cmd_ready) acc++;
            rd0 += int'(avl_rd[0]);
            rd1 += int'(avl_rd[1]);
            tick();
        end
        cmd_valid = 1'b0;
        check("credit_accepted", 64'(acc), 64'd20);
        check("credit_rd0", 64'(rd0), 64'd16);
        check("credit_rd1", 64'(rd1), 64'd16);

        // one aligned pop releases exactly one more read per channel
        rd0 = 0; rd1 = 0;
        avl_rdata_valid = 2'b11; avl_rdata = {16'h0C01, 16'h0C00};
        #1;
        rd0 += int'(avl_rd[0]); rd1 += int'(avl_rd[1]);
        tick();
        avl_rdata_valid = 2'b00;
        #1;
        check("credit_pop_valid", 64'(rdata_valid), 64'd1);
        for (int c = 0; c < 6; c++) begin
            if (c > 0) #1;
            rd0 += int'(avl_rd[0]); rd1 += int'(avl_rd[1]);
            tick();
        end
        check("credit_more_rd0", 64'(rd0), 64'd1);
        check("credit_more_rd1", 64'(rd1), 64'd1);

        // issue and pop in the same cycle leave the counter unchanged
        avl_rdata_valid = 2'b11;
        #1;
        check("sim_a0", 64'(avl_rd), 64'd0);
        tick();
        #1;
        check("sim_a1_valid", 64'(rdata_valid), 64'd1);
        check("sim_a1_rd", 64'(avl_rd), 64'd0);
        tick();
        avl_rdata_valid = 2'b00;
        #1;
        check("sim_a2_valid", 64'(rdata_valid), 64'd1);
        check("sim_a2_rd", 64'(avl_rd), 64'd3);
        tick();
        check("sim_a3_valid", 64'(rdata_valid), 64'd0);
        check("sim_a3_rd", 64'(avl_rd), 64'd3);
        tick();
        check("sim_a4_rd", 64'(avl_rd), 64'd0);
        tick();
        check("sim_a5_rd", 64'(avl_rd), 64'd0);

        // mid-operation reset
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        check("rst2_idle", 64'(idle), 64'd1);
        check("rst2_rd", 64'(avl_rd), 64'd0);

        // halt: write, read, write queued while frozen
        halt = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cmd_valid = (c < 3);
            cmd_wr    = (c != 1);
            cmd_addr  = AW'(32'h20);
            cmd_wdata = (c == 0) ? 32'h1111_0001 : 32'h2222_0002;
            #1;
            check("halt_strobes", 64'({avl_wr, avl_rd}), 64'd0);
            tick();
        end
        cmd_valid = 1'b0; halt = 1'b0;
        #1;
        check("order_w1_wr", 64'(avl_wr), 64'd3);
        check("order_w1_rd", 64'(avl_rd), 64'd0);
        check("order_w1_data", 64'(avl_wdata), 64'h1111_0001);
        check("order_w1_addr", 64'(avl_addr), both_addr(AW'(32'h20)));
        tick();
        check("order_r_rd", 64'(avl_rd), 64'd3);
        check("order_r_wr", 64'(avl_wr), 64'd0);
        tick();
        check("order_w2_wr", 64'(avl_wr), 64'd3);
        check("order_w2_data", 64'(avl_wdata), 64'h2222_0002);
        tick();
        check("order_done", 64'({avl_wr, avl_rd}), 64'd0);

        // fill command FIFOs under halt
        halt = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = AW'(32'h40 + c);
            #1;
            check("fill_ready", 64'(cmd_ready), 64'd1);
            tick();
        end
        cmd_valid = 1'b0;
        #1;
        check("full_ready", 64'(cmd_ready), 64'd0);
        rst = 1'b1; tick(); rst = 1'b0; halt = 1'b0;
        #1;
        check("rst3_ready", 64'(cmd_ready), 64'd1);

        // unexpected return
        avl_rdata_valid = 2'b01; avl_rdata = 32'h0000_DEAD;
        #1;
        tick();
        avl_rdata_valid = 2'b00;
        #1;
        check("err_set", 64'(err), 64'd1);
        check("err_no_valid", 64'(rdata_valid), 64'd0);
        tick();
        check("err_sticky", 64'(err), 64'd1);
        rst = 1'b1; tick(); rst = 1'b0;
        #1;
        check("err_cleared", 64'(err), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
